// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared constants and loader state encoding
package program_loader_pkg;

    localparam int INSTR_W = 16;
    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 5;
    localparam int BYTE_W  = 8;
    localparam int CNT_W   = 6;

    localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV_HI = 3'd1,
        ST_RECV_LO = 3'd2,
        ST_FILL    = 3'd3,
        ST_DONE    = 3'd4
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - program byte stream handshake into the loader
interface program_loader_if;
    import program_loader_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);

endinterface

// File: rtl/program_loader_instr_ram.sv
// rtl/program_loader_instr_ram.sv - DEPTH x INSTR_W instruction memory, one write port, one registered read port
module program_loader_instr_ram
    import program_loader_pkg::*;
(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Non-blocking read and write on the same edge give read-before-write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a byte-stream program into instruction memory, then serves reads by pc
module program_loader
    import program_loader_pkg::*;
(
    input  logic               PCLK,
    input  logic               RST,
    input  logic               load_start,
    program_loader_if.slave    rx,
    output logic               load_done,
    output logic [CNT_W-1:0]   load_count,
    input  logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr_out
);

    loader_state_t      state_q, state_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0]  hi_byte_q, hi_byte_d;
    logic [CNT_W-1:0]   load_count_q, load_count_d;
    logic               load_done_q;
    logic               rd_valid_q;

    logic               mem_we;
    logic [INSTR_W-1:0] mem_wdata;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] rx_word;
    logic               accept;
    logic               last_addr;

    assign rx.rx_ready = (state_q == ST_RECV_HI) || (state_q == ST_RECV_LO);
    assign accept      = rx.rx_valid && rx.rx_ready;
    assign rx_word     = {hi_byte_q, rx.rx_data};
    assign last_addr   = (wr_addr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        hi_byte_d    = hi_byte_q;
        load_count_d = load_count_q;
        mem_we       = 1'b0;
        mem_wdata    = rx_word;

        // Restart wins over everything, including a byte accepted this cycle.
        if (load_start) begin
            state_d      = ST_RECV_HI;
            wr_addr_d    = '0;
            load_count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RECV_HI: begin
                    if (accept) begin
                        hi_byte_d = rx.rx_data;
                        state_d   = ST_RECV_LO;
                    end
                end
                ST_RECV_LO: begin
                    if (accept) begin
                        mem_we       = 1'b1;
                        load_count_d = load_count_q + CNT_W'(1);
                        if (last_addr) begin
                            state_d = ST_DONE;
                        end else if (rx_word == HALT_WORD) begin
                            wr_addr_d = wr_addr_q + ADDR_W'(1);
                            state_d   = ST_FILL;
                        end else begin
                            wr_addr_d = wr_addr_q + ADDR_W'(1);
                            state_d   = ST_RECV_HI;
                        end
                    end
                end
                ST_FILL: begin
                    // Pad the tail so a pc running past the program reads HALT.
                    mem_we    = 1'b1;
                    mem_wdata = HALT_WORD;
                    if (last_addr) begin
                        state_d = ST_DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= '0;
            hi_byte_q    <= '0;
            load_count_q <= '0;
            load_done_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            hi_byte_q    <= hi_byte_d;
            load_count_q <= load_count_d;
            load_done_q  <= (state_d == ST_DONE);
            rd_valid_q   <= 1'b1;
        end
    end

    program_loader_instr_ram u_instr_ram (
        .clk_i   (PCLK),
        .we_i    (mem_we),
        .waddr_i (wr_addr_q),
        .wdata_i (mem_wdata),
        .raddr_i (pc),
        .rdata_o (mem_rdata)
    );

    // The RAM read register has no reset; gate it so instr_out reads 0 out of reset.
    assign instr_out  = rd_valid_q ? mem_rdata : '0;
    assign load_done  = load_done_q;
    assign load_count = load_count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;
    import program_loader_pkg::*;

    logic        PCLK = 1'b0;
    logic        RST = 1'b1;
    logic        load_start = 1'b0;
    logic        load_done;
    logic [5:0]  load_count;
    logic [4:0]  pc = '0;
    logic [15:0] instr_out;

    program_loader_if rx_if ();

    program_loader dut (
        .PCLK       (PCLK),
        .RST        (RST),
        .load_start (load_start),
        .rx         (rx_if),
        .load_done  (load_done),
        .load_count (load_count),
        .pc         (pc),
        .instr_out  (instr_out)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string              name;
        int                 nwords;
        logic [31:0][15:0]  words;
        bit                 gaps;
        int                 exp_count;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] model_mem [32];
    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge PCLK);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, output int waited);
        if (gaps) begin
            int idle;
            idle = $urandom_range(0, 5);
            rx_if.rx_valid = 1'b0;
            rx_if.rx_data  = 8'($urandom);
            repeat (idle) @(negedge PCLK);
        end
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        waited = 0;
        while (!rx_if.rx_ready && waited < 64) begin
            @(negedge PCLK);
            waited++;
        end
        if (waited == 64) check("rx_ready within budget", rx_if.rx_ready, 1'b1);
        @(negedge PCLK);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps, output int stall);
        int s1, s2;
        send_byte(w[15:8], gaps, s1);
        send_byte(w[7:0], gaps, s2);
        stall = s1 + s2;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!load_done && cycles < 100) begin
            @(negedge PCLK);
            cycles++;
        end
    endtask

    task automatic read_check(input logic [4:0] a, input logic [15:0] exp);
        pc = a;
        exp_q.push_back(exp);
        @(negedge PCLK);
        check($sformatf("instr_out[pc=%0d]", a), instr_out, exp_q.pop_front());
    endtask

    task automatic run_vec(input vec_t v);
        int stall_total, s, fill;
        logic [4:0] a;
        for (int i = 0; i < 32; i++)
            model_mem[i] = (i < v.nwords) ? v.words[i] : 16'hFFFF;
        pulse_start();
        stall_total = 0;
        for (int i = 0; i < v.nwords; i++) begin
            send_word(v.words[i], v.gaps, s);
            stall_total += s;
        end
        check({v.name, " load_count"}, load_count, v.exp_count);
        if (!v.gaps) check({v.name, " stall cycles"}, stall_total, 0);
        wait_done(fill);
        check({v.name, " fill cycles"}, fill, 32 - v.exp_count);
        check({v.name, " load_done"}, load_done, 1'b1);
        check({v.name, " rx_ready in DONE"}, rx_if.rx_ready, 1'b0);
        for (int i = 0; i < 32; i++) begin
            a = 5'((i * 7 + 3) % 32);
            read_check(a, model_mem[a]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, fill;

        vecs[0].name = "full";  vecs[0].nwords = 32; vecs[0].gaps = 0; vecs[0].exp_count = 32;
        vecs[1].name = "halt3"; vecs[1].nwords = 3;  vecs[1].gaps = 0; vecs[1].exp_count = 3;
        vecs[2].name = "full_gaps";  vecs[2].nwords = 32; vecs[2].gaps = 1; vecs[2].exp_count = 32;
        vecs[3].name = "halt3_gaps"; vecs[3].nwords = 3;  vecs[3].gaps = 1; vecs[3].exp_count = 3;
        vecs[4].name = "halt_first"; vecs[4].nwords = 1;  vecs[4].gaps = 0; vecs[4].exp_count = 1;
        vecs[5].name = "halt_last";  vecs[5].nwords = 32; vecs[5].gaps = 0; vecs[5].exp_count = 32;
        vecs[6].name = "halt_at30";  vecs[6].nwords = 31; vecs[6].gaps = 1; vecs[6].exp_count = 31;
        for (int i = 0; i < 32; i++) begin
            vecs[0].words[i] = 16'(i);
            vecs[2].words[i] = 16'(i);
            vecs[1].words[i] = 16'h0;
            vecs[3].words[i] = 16'h0;
            vecs[4].words[i] = 16'h0;
            vecs[5].words[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
            vecs[6].words[i] = 16'h8000 + 16'(i);
        end
        vecs[1].words[0] = 16'h1234; vecs[1].words[1] = 16'hABCD; vecs[1].words[2] = 16'hFFFF;
        vecs[3].words[0] = 16'h1234; vecs[3].words[1] = 16'hABCD; vecs[3].words[2] = 16'hFFFF;
        vecs[4].words[0] = 16'hFFFF;
        vecs[5].words[31] = 16'hFFFF;
        vecs[6].words[30] = 16'hFFFF;

        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge PCLK);
        check("reset load_done", load_done, 1'b0);
        check("reset rx_ready", rx_if.rx_ready, 1'b0);
        check("reset load_count", load_count, 6'd0);
        check("reset instr_out", instr_out, 16'h0);
        RST = 1'b0;
        @(negedge PCLK);

        // Table-driven loads with scoreboard readback
        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Restart mid-word; the byte colliding with load_start is dropped
        pulse_start();
        send_byte(8'h12, 0, s);
        check("mid-word rx_ready", rx_if.rx_ready, 1'b1);
        load_start = 1'b1;
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = 8'h34;
        @(negedge PCLK);
        load_start = 1'b0;
        rx_if.rx_valid = 1'b0;
        check("restart load_count", load_count, 6'd0);
        send_word(16'h5566, 0, s);
        check("restart word load_count", load_count, 6'd1);
        check("restart load_done", load_done, 1'b0);
        read_check(5'd0, 16'h5566);
        send_word(16'hFFFF, 0, s);
        check("restart halt load_count", load_count, 6'd2);
        wait_done(fill);
        check("restart fill cycles", fill, 30);
        read_check(5'd1, 16'hFFFF);

        // Restart from DONE
        check("done before restart", load_done, 1'b1);
        pulse_start();
        check("done dropped", load_done, 1'b0);
        check("done restart load_count", load_count, 6'd0);
        check("done restart rx_ready", rx_if.rx_ready, 1'b1);

        // Async reset mid-FILL
        send_word(16'h1234, 0, s);
        send_word(16'hFFFF, 0, s);
        pc = 5'd0;
        repeat (5) @(negedge PCLK);
        check("pre-reset instr_out", instr_out, 16'h1234);
        check("pre-reset load_count", load_count, 6'd2);
        #2;
        RST = 1'b1;
        #1;
        check("async load_done", load_done, 1'b0);
        check("async rx_ready", rx_if.rx_ready, 1'b0);
        check("async load_count", load_count, 6'd0);
        check("async instr_out", instr_out, 16'h0);
        @(negedge PCLK);
        RST = 1'b0;
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = 8'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("idle rx_ready", rx_if.rx_ready, 1'b0);
            check("idle load_count", load_count, 6'd0);
        end
        check("idle load_done", load_done, 1'b0);

        // Start/data collision in IDLE
        load_start = 1'b1;
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = 8'hAA;
        check("collision rx_ready", rx_if.rx_ready, 1'b0);
        @(negedge PCLK);
        load_start = 1'b0;
        send_byte(8'hAA, 0, s);
        send_byte(8'hBB, 0, s);
        send_word(16'hFFFF, 0, s);
        check("collision load_count", load_count, 6'd2);
        wait_done(fill);
        check("collision fill cycles", fill, 30);
        read_check(5'd0, 16'hAABB);
        read_check(5'd1, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
